// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory accessor port between fetch (read-only) and load/store units
// Optional round-robin arbitration is enabled by defining MEM_PORT_ARB_RR_EN.

`ifndef ARCH_SIZE
`define ARCH_SIZE 16
`endif

module mem_port_arbiter #(
    parameter int ADDR_W  = `ARCH_SIZE,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [15:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_ack,
    output logic [15:0]       d_rdata,
    output logic              d_err,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic              mem_read_ready,
    input  logic [15:0]       mem_read_value,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [15:0]       mem_write_value,
    input  logic              mem_write_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int           WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [7:0]   WD_LAST   = WD_LAST_I[7:0];

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [7:0]          wd_cnt_q, wd_cnt_d;
    logic                mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]   mem_read_address_q, mem_read_address_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_write_address_q, mem_write_address_d;
    logic [15:0]         mem_write_value_q, mem_write_value_d;
    logic                if_ack_q, if_ack_d;
    logic [15:0]         if_rdata_q, if_rdata_d;
    logic                if_err_q, if_err_d;
    logic                d_ack_q, d_ack_d;
    logic [15:0]         d_rdata_q, d_rdata_d;
    logic                d_err_q, d_err_d;
    logic                pick_data;
    logic                wd_expire;

`ifdef MEM_PORT_ARB_RR_EN
    logic                last_owner_q, last_owner_d;

    // On a tie the requester that was not served last wins.
    assign pick_data = d_req && (!if_req || (last_owner_q == OWN_F));
`else
    assign pick_data = d_req;
`endif

    assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        wd_cnt_d            = wd_cnt_q;
        mem_read_d          = mem_read_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_d         = mem_write_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_value_d   = mem_write_value_q;
        if_ack_d            = 1'b0;
        if_rdata_d          = 16'h0000;
        if_err_d            = 1'b0;
        d_ack_d             = 1'b0;
        d_rdata_d           = 16'h0000;
        d_err_d             = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
        last_owner_d        = last_owner_q;
`endif

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d  = pick_data ? OWN_D : OWN_F;
                    wd_cnt_d = 8'd0;
                    if (pick_data && d_we) begin
                        state_d             = WR_WAIT;
                        mem_write_d         = 1'b1;
                        mem_write_address_d = d_addr;
                        mem_write_value_d   = d_wdata;
                    end else begin
                        state_d            = RD_WAIT;
                        mem_read_d         = 1'b1;
                        mem_read_address_d = pick_data ? d_addr : if_addr;
                    end
                end
            end

            RD_WAIT: begin
                if (mem_read_ready || wd_expire) begin
                    // Ready in the expiry cycle still counts as a normal completion.
                    state_d            = ACK;
                    mem_read_d         = 1'b0;
                    mem_read_address_d = '0;
                    if (owner_q == OWN_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_read_ready ? mem_read_value : 16'h0000;
                        d_err_d   = !mem_read_ready;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_read_ready ? mem_read_value : 16'h0000;
                        if_err_d   = !mem_read_ready;
                    end
                end else if (wd_cnt_q != 8'hFF) begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end

            WR_WAIT: begin
                if (mem_write_ready || wd_expire) begin
                    state_d             = ACK;
                    mem_write_d         = 1'b0;
                    mem_write_address_d = '0;
                    mem_write_value_d   = 16'h0000;
                    if (owner_q == OWN_D) begin
                        d_ack_d = 1'b1;
                        d_err_d = !mem_write_ready;
                    end else begin
                        if_ack_d = 1'b1;
                        if_err_d = !mem_write_ready;
                    end
                end else if (wd_cnt_q != 8'hFF) begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end

            ACK: begin
                state_d = IDLE;
`ifdef MEM_PORT_ARB_RR_EN
                last_owner_d = owner_q;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q             <= IDLE;
            owner_q             <= OWN_F;
            wd_cnt_q            <= 8'd0;
            mem_read_q          <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_q         <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_value_q   <= 16'h0000;
            if_ack_q            <= 1'b0;
            if_rdata_q          <= 16'h0000;
            if_err_q            <= 1'b0;
            d_ack_q             <= 1'b0;
            d_rdata_q           <= 16'h0000;
            d_err_q             <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            last_owner_q        <= OWN_F;
`endif
        end else begin
            state_q             <= state_d;
            owner_q             <= owner_d;
            wd_cnt_q            <= wd_cnt_d;
            mem_read_q          <= mem_read_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_q         <= mem_write_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_value_q   <= mem_write_value_d;
            if_ack_q            <= if_ack_d;
            if_rdata_q          <= if_rdata_d;
            if_err_q            <= if_err_d;
            d_ack_q             <= d_ack_d;
            d_rdata_q           <= d_rdata_d;
            d_err_q             <= d_err_d;
`ifdef MEM_PORT_ARB_RR_EN
            last_owner_q        <= last_owner_d;
`endif
        end
    end

    assign if_ack            = if_ack_q;
    assign if_rdata          = if_rdata_q;
    assign if_err            = if_err_q;
    assign d_ack             = d_ack_q;
    assign d_rdata           = d_rdata_q;
    assign d_err             = d_err_q;
    assign mem_read          = mem_read_q;
    assign mem_read_address  = mem_read_address_q;
    assign mem_write         = mem_write_q;
    assign mem_write_address = mem_write_address_q;
    assign mem_write_value   = mem_write_value_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter with a 4-cycle watchdog

module tb_mem_port_arbiter;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [15:0]   if_rdata;
    logic          if_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [15:0]   d_wdata;
    logic          d_ack;
    logic [15:0]   d_rdata;
    logic          d_err;
    logic          mem_read;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [15:0]   mem_read_value;
    logic          mem_write;
    logic [AW-1:0] mem_write_address;
    logic [15:0]   mem_write_value;
    logic          mem_write_ready;
    logic          busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_ack            (if_ack),
        .if_rdata          (if_rdata),
        .if_err            (if_err),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_ack             (d_ack),
        .d_rdata           (d_rdata),
        .d_err             (d_err),
        .mem_read          (mem_read),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_value    (mem_read_value),
        .mem_write         (mem_write),
        .mem_write_address (mem_write_address),
        .mem_write_value   (mem_write_value),
        .mem_write_ready   (mem_write_ready),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        int          wait_cyc;
        logic [15:0] rval;
        logic        exp_d;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_strobes;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic outputs_nonzero();
        return |{if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, mem_read, mem_read_address,
                 mem_write, mem_write_address, mem_write_value, busy};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic        strobe;
        logic        acked;
        logic [15:0] got_rdata;
        logic        got_err;
        int          strobes;
        int          cyc;
        int          ack_cyc;
        int          bad_addr;
        int          bad_strobe;
        int          wrong_ack;
        string       tag;
        exp_wr     = v.exp_d && v.d_we;
        exp_addr   = v.exp_d ? v.d_addr : v.if_addr;
        acked      = 1'b0;
        got_rdata  = 16'h0000;
        got_err    = 1'b0;
        strobes    = 0;
        cyc        = 0;
        ack_cyc    = -1;
        bad_addr   = 0;
        bad_strobe = 0;
        wrong_ack  = 0;
        tag        = $sformatf("vec%0d", idx);

        @(negedge clk);
        if_req  = v.if_req;
        if_addr = v.if_addr;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        // The non-matching ready is held high to show it is ignored.
        mem_read_ready  = exp_wr;
        mem_read_value  = exp_wr ? 16'hFFFF : v.rval;
        mem_write_ready = !exp_wr;

        while (!acked && cyc < 50) begin
            @(negedge clk);
            cyc++;
            strobe = exp_wr ? mem_write : mem_read;
            if (mem_read && mem_write) bad_strobe++;
            if (exp_wr ? mem_read : mem_write) bad_strobe++;
            if (strobe) begin
                strobes++;
                if ((exp_wr ? mem_write_address : mem_read_address) !== exp_addr) bad_addr++;
                if (exp_wr && (mem_write_value !== v.d_wdata)) bad_addr++;
            end
            if (v.exp_d ? if_ack : d_ack) wrong_ack++;
            if (v.exp_d ? d_ack : if_ack) begin
                acked     = 1'b1;
                ack_cyc   = cyc;
                got_rdata = v.exp_d ? d_rdata : if_rdata;
                got_err   = v.exp_d ? d_err : if_err;
                if_req    = 1'b0;
                d_req     = 1'b0;
            end
            if (exp_wr) mem_write_ready = strobe && (strobes == v.wait_cyc + 1);
            else        mem_read_ready  = strobe && (strobes == v.wait_cyc + 1);
        end

        check({tag, "_ack_seen"}, {31'd0, acked}, 32'd1);
        check({tag, "_rdata"}, {16'd0, got_rdata}, {16'd0, v.exp_rdata});
        check({tag, "_err"}, {31'd0, got_err}, {31'd0, v.exp_err});
        check({tag, "_strobe_cycles"}, strobes, v.exp_strobes);
        check({tag, "_ack_cycle"}, ack_cyc, v.exp_strobes + 1);
        check({tag, "_addr_data"}, bad_addr, 0);
        check({tag, "_strobe_excl"}, bad_strobe, 0);
        check({tag, "_other_ack"}, wrong_ack, 0);

        @(negedge clk);
        check({tag, "_ack_pulse"}, {30'd0, if_ack, d_ack}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
    endtask

    initial begin
        int   grants[$];
        int   ncyc;
        int   acks_in_reset;
        logic exp_seq[4];

        //           if_req ifaddr    d_req we    daddr     wdata     wait rval      exp_d exp_rd    err   strb
        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,   16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h1234, 3,   16'h0000, 1'b1, 16'h0000, 1'b0, 4};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h0000, 1,   16'hA5A5, 1'b1, 16'hA5A5, 1'b0, 2};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0304, 16'h0000, 255, 16'h7777, 1'b1, 16'h0000, 1'b1, 4};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0308, 16'h0000, 3,   16'h5A5A, 1'b1, 16'h5A5A, 1'b0, 4};
`ifdef MEM_PORT_ARB_RR_EN
        vecs[5] = '{1'b1, 16'h0044, 1'b1, 1'b0, 16'h0400, 16'h0000, 0,   16'h1111, 1'b0, 16'h1111, 1'b0, 1};
`else
        vecs[5] = '{1'b1, 16'h0044, 1'b1, 1'b0, 16'h0400, 16'h0000, 0,   16'h1111, 1'b1, 16'h1111, 1'b0, 1};
`endif
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0500, 16'hCAFE, 255, 16'h0000, 1'b1, 16'h0000, 1'b1, 4};
        vecs[7] = '{1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 2,   16'h0F0F, 1'b0, 16'h0F0F, 1'b0, 3};

        reset_n         = 1'b0;
        if_req          = 1'b0;
        if_addr         = '0;
        d_req           = 1'b0;
        d_we            = 1'b0;
        d_addr          = '0;
        d_wdata         = 16'h0000;
        mem_read_ready  = 1'b0;
        mem_read_value  = 16'h0000;
        mem_write_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", {31'd0, outputs_nonzero()}, 32'd0);
        reset_n = 1'b1;

        // Both requesters held high with zero-wait memory.
`ifdef MEM_PORT_ARB_RR_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(negedge clk);
        if_req         = 1'b1;
        if_addr        = 16'h0100;
        d_req          = 1'b1;
        d_we           = 1'b0;
        d_addr         = 16'h0200;
        mem_read_value = 16'h3C3C;
        mem_read_ready = 1'b1;
        ncyc = 0;
        while (grants.size() < 4 && ncyc < 40) begin
            @(negedge clk);
            ncyc++;
            if (if_ack) grants.push_back(0);
            if (d_ack)  grants.push_back(1);
        end
        if_req         = 1'b0;
        d_req          = 1'b0;
        mem_read_ready = 1'b0;
        check("tie_grant_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size())
                check($sformatf("tie_grant%0d_is_data", i), grants[i], {31'd0, exp_seq[i]});
        end
        repeat (3) @(negedge clk);
        check("tie_back_to_idle", {31'd0, busy}, 32'd0);

        // Reset arriving while a fetch waits on memory.
        if_req  = 1'b1;
        if_addr = 16'h0080;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_strobe_before", {31'd0, mem_read}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_strobe_dropped", {31'd0, mem_read}, 32'd0);
        check("rst_mid_outputs_zero", {31'd0, outputs_nonzero()}, 32'd0);
        @(negedge clk);
        check("rst_mid_outputs_zero2", {31'd0, outputs_nonzero()}, 32'd0);
        if_req  = 1'b0;
        reset_n = 1'b1;
        acks_in_reset = 0;
        repeat (4) begin
            @(negedge clk);
            if (if_ack || d_ack || busy) acks_in_reset++;
        end
        check("rst_mid_no_ack", acks_in_reset, 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory accessor port (read/write strobes, address, 16-bit data, ready handshakes) between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Sits between the core front-end/LSU and the memory model.
- Serialises accesses, registers all memory-side outputs, returns data or an error per request, and aborts accesses that never complete via a watchdog.

Parameters:
- ADDR_W, `ARCH_SIZE: address width, matching the accessor address bus.
- TIMEOUT, 255: maximum wait cycles for mem ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request (level)
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  16  fetch data; valid while if_ack=1
- if_err  out  1  timeout flag; valid with if_ack
- d_req  in  1  data request (level)
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  16  write data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  16  load data; valid while d_ack=1
- d_err  out  1  timeout flag; valid with d_ack
- mem_read  out  1  read strobe
- mem_read_address  out  ADDR_W  read address
- mem_read_ready  in  1  read_value valid / read done
- mem_read_value  in  16  read data
- mem_write  out  1  write strobe
- mem_write_address  out  ADDR_W  write address
- mem_write_value  out  16  write data
- mem_write_ready  in  1  write accepted
- busy  out  1  1 whenever state != IDLE

Behaviour:
- **Reset** (reset_n=0 at a clk edge): state=IDLE. All outputs 0, including strobes, acks, errs, rdata, addresses, write_value, busy and the watchdog count. Any in-flight access is dropped without an ack.
- **States:** IDLE, RD_WAIT, WR_WAIT, ACK.
- **IDLE:**
  - No request pending: stay in IDLE.
  - One or both requests pending: grant one per the priority rule.
  - At grant: latch owner, address, we and wdata. Requester inputs are ignored after this cycle.
  - Next state is RD_WAIT (fetch, or d_we=0) or WR_WAIT (d_we=1).
- **RD_WAIT:**
  - mem_read=1 and mem_read_address=latched address, registered, asserted from the cycle after grant.
  - On mem_read_ready=1: capture mem_read_value and go to ACK. mem_read drops in the ACK cycle.
- **WR_WAIT:**
  - mem_write=1 with latched address and value.
  - On mem_write_ready=1: go to ACK. rdata is 0 for writes.
- **Handshake and timing:**
  - mem_read and mem_write are never both 1.
  - Ready inputs are ignored outside the matching wait state.
- **ACK:**
  - The owner's ack=1 for exactly one cycle, with rdata/err valid. The other requester's ack stays 0.
  - Next state is IDLE unconditionally.
- **Minimum latency** (zero-wait memory): req at cycle 0, strobe at cycle 1, ready at cycle 1, ack at cycle 2, IDLE at cycle 3. Peak throughput is one access per 3 cycles.
- **Requester obligations:**
  - Hold req and the request fields until ack.
  - req still high in the cycle after ack is treated as a new request.
  - Dropping req before ack does not cancel the access; the ack is still produced.
- **Priority (default):** fixed, data over fetch on simultaneous requests.
- **Watchdog:**
  - 8-bit counter cleared on entry to RD_WAIT/WR_WAIT, incremented each wait cycle without ready.
  - With TIMEOUT!=0: if ready is still 0 when count == TIMEOUT-1, drop the strobe and go to ACK with err=1 and rdata=0.
  - Ready arriving in the same cycle as expiry wins: normal completion, err=0.
  - With TIMEOUT=0 the wait is unbounded.
- **Reset mid-access:** the strobe is 0 in the cycle after the reset edge, and no ack is issued.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: round-robin priority.
  - A 1-bit last_owner register (reset = fetch) is updated at each ACK.
  - On simultaneous requests, the non-last owner wins.
  - A single pending request is always granted.
- Undefined: fixed data-over-fetch priority; no last_owner register.

Test Plan:
- **Reset mid-read:** reset_n=0 for 2 cycles during RD_WAIT → all outputs 0, no if_ack/d_ack, busy=0; next if_req is granted normally.
- **Zero-wait fetch:** if_req=1, if_addr=0x0010; memory returns ready same cycle with 0xBEEF → mem_read high at cycle 1, if_ack=1 with if_rdata=0xBEEF at cycle 2, busy=0 at cycle 3.
- **Write with 3 wait cycles:** d_req=1, d_we=1, d_addr=0x0200, d_wdata=0x1234 → mem_write high for 4 cycles with address 0x0200 and value 0x1234, d_ack pulse once, d_err=0, mem_read never high.
- **Simultaneous requests, macro undefined:** if_req and d_req held → grants alternate D, F, D, F only as each requester re-requests; with both always high, data is granted every time and fetch starves.
- **Simultaneous requests, MEM_PORT_ARB_RR_EN defined:** if_req and d_req held for 4 accesses → grant order D, F, D, F (last_owner reset = fetch).
- **Timeout, TIMEOUT=4:** d read, ready never asserted → mem_read high exactly 4 cycles, then d_ack=1, d_err=1, d_rdata=0. Repeat with ready on the 4th wait cycle → d_err=0 and data returned.
